// File: rtl/mask_rng_source.sv
// Fresh-mask randomness source: a seeded 32-bit Galois LFSR with warm-up and a per-seed
// beat budget, streaming N_RAND bits per beat over a valid/ready handshake.
module mask_rng_source #(
  parameter int unsigned N_RAND       = 3,
  parameter int unsigned WARMUP       = 32,
  parameter int unsigned RESEED_LIMIT = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_seed,
  input  logic              i_seed_valid,
  output logic              o_seed_ready,
  output logic [N_RAND-1:0] o_r,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_need_seed,
  output logic              o_seed_err
);

  localparam logic [31:0] Taps     = 32'h80200003;
  localparam logic [7:0]  WarmInit = 8'(WARMUP);
  localparam logic [16:0] Limit    = 17'(RESEED_LIMIT);

  typedef enum logic [1:0] {StIdle, StWarm, StRun} state_e;

  state_e            state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [7:0]        warm_cnt_q, warm_cnt_d;
  logic [15:0]       beat_cnt_q, beat_cnt_d;
  logic              valid_q;
  logic [N_RAND-1:0] r_q;
  logic              seed_err_q;

  logic        seed_ready;
  logic        seed_acc;
  logic        seed_ok;
  logic        beat;
  logic [16:0] beat_sum;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = (s >> 1) ^ (s[0] ? Taps : 32'h0);
  endfunction

  always_comb begin
    seed_ready = (state_q != StWarm);
    seed_acc   = i_seed_valid && seed_ready;
    seed_ok    = seed_acc && (i_seed != 32'h0);
    // valid_q is only ever high while in RUN
    beat       = valid_q && i_ready;
    beat_sum   = {1'b0, beat_cnt_q} + 17'd1;

    state_d    = state_q;
    lfsr_d     = lfsr_q;
    warm_cnt_d = warm_cnt_q;
    beat_cnt_d = beat_cnt_q;

    unique case (state_q)
      StIdle: ;
      StWarm: begin
        lfsr_d     = lfsr_step(lfsr_q);
        warm_cnt_d = warm_cnt_q - 8'd1;
        if (warm_cnt_q == 8'd1) state_d = StRun;
      end
      StRun: begin
        if (beat) begin
          lfsr_d     = lfsr_step(lfsr_q);
          beat_cnt_d = beat_sum[15:0];
          // Leave on the edge of the last permitted beat so no extra beat can slip out
          if (beat_sum == Limit) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A good seed wins over both the limit and a concurrent beat
    if (seed_ok) begin
      lfsr_d     = i_seed;
      warm_cnt_d = WarmInit;
      beat_cnt_d = 16'h0;
      state_d    = StWarm;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      lfsr_q     <= 32'h00000001;
      warm_cnt_q <= 8'h0;
      beat_cnt_q <= 16'h0;
      valid_q    <= 1'b0;
      r_q        <= '0;
      seed_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      warm_cnt_q <= warm_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      valid_q    <= (state_d == StRun);
      r_q        <= (state_d == StRun) ? lfsr_d[N_RAND-1:0] : '0;
      seed_err_q <= seed_acc && (i_seed == 32'h0);
    end
  end

  assign o_seed_ready = seed_ready;
  assign o_need_seed  = (state_q == StIdle);
  assign o_valid      = valid_q;
  assign o_r          = r_q;
  assign o_seed_err   = seed_err_q;

endmodule

// File: tb/tb_mask_rng_source.sv
// Directed bench for mask_rng_source with WARMUP=1 and RESEED_LIMIT=4; expected LFSR
// values are hand-computed constants.
module tb_mask_rng_source;

  logic        clk;
  logic        rst;
  logic [31:0] seed;
  logic        seed_valid;
  logic        seed_ready;
  logic [2:0]  r;
  logic        valid;
  logic        ready;
  logic        need_seed;
  logic        seed_err;

  int total = 0;
  int bad   = 0;
  int beats_seen = 0;

  mask_rng_source #(
    .N_RAND      (3),
    .WARMUP      (1),
    .RESEED_LIMIT(4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_seed      (seed),
    .i_seed_valid(seed_valid),
    .o_seed_ready(seed_ready),
    .o_r         (r),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_need_seed (need_seed),
    .o_seed_err  (seed_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && valid && ready) beats_seen++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; seed = 32'h0; seed_valid = 1'b0; ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_need", 32'(need_seed), 32'd1);
    chk("rst_ready", 32'(seed_ready), 32'd1);
    chk("rst_err", 32'(seed_err), 32'd0);
    chk("rst_lfsr", dut.lfsr_q, 32'h00000001);

    // Zero seed is rejected with a one-cycle error pulse
    seed = 32'h0; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    chk("zero_err", 32'(seed_err), 32'd1);
    chk("zero_need", 32'(need_seed), 32'd1);
    chk("zero_valid", 32'(valid), 32'd0);
    chk("zero_lfsr", dut.lfsr_q, 32'h00000001);
    tick();
    chk("zero_err_drop", 32'(seed_err), 32'd0);
    chk("zero_still_idle", 32'(need_seed), 32'd1);

    // Seed 1, WARMUP=1: valid two cycles after the handshake cycle
    seed = 32'h1; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    chk("warm_ready", 32'(seed_ready), 32'd0);
    chk("warm_valid", 32'(valid), 32'd0);
    chk("warm_need", 32'(need_seed), 32'd0);
    tick();
    chk("run_valid", 32'(valid), 32'd1);
    chk("run_r0", 32'(r), 32'd3);
    chk("run_lfsr0", dut.lfsr_q, 32'h80200003);

    // Stall: output and beat counter hold
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_r", 32'(r), 32'd3);
    end
    chk("stall_cnt", 32'(dut.beat_cnt_q), 32'd0);
    chk("stall_valid", 32'(valid), 32'd1);

    // Four beats then the budget is spent
    beats_seen = 0;
    ready = 1'b1;
    tick();
    chk("beat1_r", 32'(r), 32'd2);     // 0xC0300002
    chk("beat1_valid", 32'(valid), 32'd1);
    tick();
    chk("beat2_r", 32'(r), 32'd1);     // 0x60180001
    tick();
    chk("beat3_r", 32'(r), 32'd3);     // 0xB02C0003
    chk("beat3_valid", 32'(valid), 32'd1);
    tick();
    chk("limit_valid", 32'(valid), 32'd0);
    chk("limit_need", 32'(need_seed), 32'd1);
    chk("limit_lfsr", dut.lfsr_q, 32'hD8360002);
    tick(); tick();
    chk("limit_beats", 32'(beats_seen), 32'd4);
    chk("idle_lfsr_hold", dut.lfsr_q, 32'hD8360002);
    chk("idle_valid", 32'(valid), 32'd0);

    // Seed during a beat: beat completes, then WARM
    ready = 1'b0;
    seed = 32'h12345678; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    tick();
    chk("s2_valid", 32'(valid), 32'd1);
    chk("s2_r0", 32'(r), 32'd4);       // 0x091A2B3C
    beats_seen = 0;
    ready = 1'b1;
    tick();
    chk("s2_r1", 32'(r), 32'd6);       // 0x048D159E
    chk("s2_cnt1", 32'(dut.beat_cnt_q), 32'd1);
    seed = 32'hA5A5A5A5; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    chk("collide_beats", 32'(beats_seen), 32'd2);
    chk("collide_valid", 32'(valid), 32'd0);
    chk("collide_warm", 32'(seed_ready), 32'd0);
    chk("collide_lfsr", dut.lfsr_q, 32'hA5A5A5A5);

    // Reset during WARM
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("warm_rst_need", 32'(need_seed), 32'd1);
    chk("warm_rst_valid", 32'(valid), 32'd0);
    chk("warm_rst_lfsr", dut.lfsr_q, 32'h00000001);
    tick();
    chk("warm_rst_stays", 32'(valid), 32'd0);

    // Seed offered on the same cycle the limit is reached
    ready = 1'b0;
    seed = 32'h1; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    tick();
    ready = 1'b1;
    tick(); tick(); tick();
    chk("pre_limit_cnt", 32'(dut.beat_cnt_q), 32'd3);
    seed = 32'h00000005; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    chk("limit_seed_warm", 32'(seed_ready), 32'd0);
    chk("limit_seed_need", 32'(need_seed), 32'd0);
    chk("limit_seed_lfsr", dut.lfsr_q, 32'h00000005);
    tick();
    chk("limit_seed_run_r", 32'(r), 32'd1);  // step(5) = 0x80200001

    // Reset wins over a simultaneous seed and beat
    rst = 1'b1; seed = 32'h77; seed_valid = 1'b1;
    tick();
    rst = 1'b0; seed_valid = 1'b0;
    chk("rst_prio_need", 32'(need_seed), 32'd1);
    chk("rst_prio_lfsr", dut.lfsr_q, 32'h00000001);
    chk("rst_prio_valid", 32'(valid), 32'd0);
    chk("rst_prio_r", 32'(r), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
